// File: rtl/sccpu_pkg.sv
// Shared sccpu control definitions: opcodes, functs, ALU codes, FSM state and mux encodings.
// Latency: none, this package holds only constants and types.
// Backpressure: none, this package holds only constants and types.
package sccpu_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // al_unit operation codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // PC source and register-destination mux selects
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_JR   = 2'b11;
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  // Instruction classes: what decides the FSM path after ID
  typedef enum logic [3:0] {
    CL_ILL, CL_RALU, CL_JR, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL
  } iclass_e;

endpackage

// File: rtl/cu_decode.sv
// Instruction decoder: op/func -> class, ALU op and operand-select controls.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs track the IR fields continuously.
module cu_decode
  import sccpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output iclass_e    cls_o,
  output logic [3:0] aluc_o,
  output logic       sext_o,
  output logic       aluimm_o,
  output logic       shift_o,
  output logic       illegal_o
);

  // Map every supported encoding to its class and ALU controls; anything else is illegal
  always_comb begin
    cls_o    = CL_ILL;
    aluc_o   = ALUC_ADD;
    sext_o   = 1'b0;
    aluimm_o = 1'b0;
    shift_o  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD: begin cls_o = CL_RALU; aluc_o = ALUC_ADD; end
          FN_SUB: begin cls_o = CL_RALU; aluc_o = ALUC_SUB; end
          FN_AND: begin cls_o = CL_RALU; aluc_o = ALUC_AND; end
          FN_OR:  begin cls_o = CL_RALU; aluc_o = ALUC_OR;  end
          FN_XOR: begin cls_o = CL_RALU; aluc_o = ALUC_XOR; end
          FN_SLL: begin cls_o = CL_RALU; aluc_o = ALUC_SLL; shift_o = 1'b1; end
          FN_SRL: begin cls_o = CL_RALU; aluc_o = ALUC_SRL; shift_o = 1'b1; end
          FN_SRA: begin cls_o = CL_RALU; aluc_o = ALUC_SRA; shift_o = 1'b1; end
          FN_JR:  cls_o = CL_JR;
          default: cls_o = CL_ILL;
        endcase
      end
      OP_ADDI: begin cls_o = CL_IALU; aluc_o = ALUC_ADD; aluimm_o = 1'b1; sext_o = 1'b1; end
      OP_ANDI: begin cls_o = CL_IALU; aluc_o = ALUC_AND; aluimm_o = 1'b1; end
      OP_ORI:  begin cls_o = CL_IALU; aluc_o = ALUC_OR;  aluimm_o = 1'b1; end
      OP_XORI: begin cls_o = CL_IALU; aluc_o = ALUC_XOR; aluimm_o = 1'b1; end
      OP_LUI:  begin cls_o = CL_IALU; aluc_o = ALUC_LUI; aluimm_o = 1'b1; end
      OP_LW:   begin cls_o = CL_LW;   aluc_o = ALUC_ADD; aluimm_o = 1'b1; sext_o = 1'b1; end
      OP_SW:   begin cls_o = CL_SW;   aluc_o = ALUC_ADD; aluimm_o = 1'b1; sext_o = 1'b1; end
      OP_BEQ:  begin cls_o = CL_BEQ;  aluc_o = ALUC_SUB; sext_o = 1'b1; end
      OP_BNE:  begin cls_o = CL_BNE;  aluc_o = ALUC_SUB; sext_o = 1'b1; end
      OP_J:    cls_o = CL_J;
      OP_JAL:  cls_o = CL_JAL;
      default: cls_o = CL_ILL;
    endcase
    illegal_o = (cls_o == CL_ILL);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle sccpu control: IF/ID/EXE/MEM/WB sequencing, datapath strobes, retire counter.
// Latency (mem_rdy=1): j/jal/jr 2, beq/bne 3, ALU and sw 4, lw 5 cycles; stalls add cycles.
// Backpressure: holds IF/MEM while mem_rdy=0; optional timeout aborts with a cu_bus_err pulse.
module mc_control_unit
  import sccpu_pkg::*;
#(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           ir_op,
  input  logic [5:0]           ir_func,
  input  logic                 alu_zero,
  input  logic                 mem_rdy,
  output logic [3:0]           cu_aluc,
  output logic                 cu_pcwr,
  output logic [1:0]           cu_pcsrc,
  output logic                 cu_irwr,
  output logic                 cu_memrd,
  output logic                 cu_memwr,
  output logic                 cu_regwr,
  output logic [1:0]           cu_regdst,
  output logic                 cu_m2reg,
  output logic                 cu_aluimm,
  output logic                 cu_shift,
  output logic                 cu_sext,
  output logic                 cu_jal,
  output logic                 cu_illegal,
  output logic                 cu_bus_err,
  output logic [2:0]           cu_state,
  output logic [INSTRET_W-1:0] cu_instret
);

  localparam logic                 TO_EN     = (MEM_TIMEOUT != 0);
  localparam logic [31:0]          WAIT_LAST = 32'(MEM_TIMEOUT - 1);
  localparam logic [INSTRET_W-1:0] RET_ONE   = INSTRET_W'(1);

  state_e                 state_q, state_d;
  logic [31:0]            wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;
  logic                   timeout;
  logic                   waiting;

  iclass_e                cls;
  logic [3:0]             dec_aluc;
  logic                   dec_sext, dec_aluimm, dec_shift, dec_illegal;

  cu_decode u_decode (
    .op_i      (ir_op),
    .func_i    (ir_func),
    .cls_o     (cls),
    .aluc_o    (dec_aluc),
    .sext_o    (dec_sext),
    .aluimm_o  (dec_aluimm),
    .shift_o   (dec_shift),
    .illegal_o (dec_illegal)
  );

  // A memory wait expires on its last allowed cycle unless mem_rdy arrives that same cycle
  assign waiting = (state_q == S_IF || state_q == S_MEM) && !mem_rdy;
  assign timeout = TO_EN && waiting && (wait_q == WAIT_LAST);

  // State, wait counter and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Wait counter: counts stalled IF/MEM cycles, restarts on any state change or timeout
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q || timeout) wait_d = '0;
    else if (waiting)                  wait_d = wait_q + 32'd1;
    instret_d = retire ? instret_q + RET_ONE : instret_q;
  end

  // Next state and datapath strobes; everything forced low while reset is asserted
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    cu_aluc    = ALUC_ADD;
    cu_pcwr    = 1'b0;
    cu_pcsrc   = PCSRC_SEQ;
    cu_irwr    = 1'b0;
    cu_memrd   = 1'b0;
    cu_memwr   = 1'b0;
    cu_regwr   = 1'b0;
    cu_regdst  = REGDST_RT;
    cu_m2reg   = 1'b0;
    cu_aluimm  = 1'b0;
    cu_shift   = 1'b0;
    cu_sext    = 1'b0;
    cu_jal     = 1'b0;
    cu_illegal = 1'b0;
    cu_bus_err = 1'b0;
    case (state_q)
      S_IF: begin
        cu_memrd = 1'b1;
        if (mem_rdy) begin
          cu_irwr = 1'b1;
          cu_pcwr = 1'b1;
          state_d = S_ID;
        end else if (timeout) begin
          cu_bus_err = 1'b1;
        end
      end
      S_ID: begin
        state_d = S_IF;
        case (cls)
          CL_J:   begin cu_pcwr = 1'b1; cu_pcsrc = PCSRC_JMP; retire = 1'b1; end
          CL_JAL: begin
            cu_pcwr = 1'b1; cu_pcsrc = PCSRC_JMP; cu_regwr = 1'b1;
            cu_regdst = REGDST_R31; cu_jal = 1'b1; retire = 1'b1;
          end
          CL_JR:  begin cu_pcwr = 1'b1; cu_pcsrc = PCSRC_JR; retire = 1'b1; end
          CL_ILL: cu_illegal = dec_illegal;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        cu_aluc   = dec_aluc;
        cu_sext   = dec_sext;
        cu_aluimm = dec_aluimm;
        cu_shift  = dec_shift;
        case (cls)
          CL_BEQ, CL_BNE: begin
            if ((cls == CL_BEQ) == alu_zero) begin
              cu_pcwr  = 1'b1;
              cu_pcsrc = PCSRC_BR;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end
          CL_LW, CL_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Effective address stays on the ALU for the whole access
        cu_aluc   = ALUC_ADD;
        cu_sext   = dec_sext;
        cu_aluimm = dec_aluimm;
        if (cls == CL_LW) cu_memrd = 1'b1;
        if (cls == CL_SW) cu_memwr = !timeout;
        if (mem_rdy) begin
          state_d = (cls == CL_LW) ? S_WB : S_IF;
          retire  = (cls != CL_LW);
        end else if (timeout) begin
          cu_bus_err = 1'b1;
          state_d    = S_IF;
        end
      end
      S_WB: begin
        cu_regwr  = 1'b1;
        cu_regdst = (cls == CL_RALU) ? REGDST_RD : REGDST_RT;
        cu_m2reg  = (cls == CL_LW);
        retire    = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
    cu_state = state_q;
    if (!rst_n) begin
      cu_aluc    = '0;
      cu_pcwr    = 1'b0;
      cu_pcsrc   = '0;
      cu_irwr    = 1'b0;
      cu_memrd   = 1'b0;
      cu_memwr   = 1'b0;
      cu_regwr   = 1'b0;
      cu_regdst  = '0;
      cu_m2reg   = 1'b0;
      cu_aluimm  = 1'b0;
      cu_shift   = 1'b0;
      cu_sext    = 1'b0;
      cu_jal     = 1'b0;
      cu_illegal = 1'b0;
      cu_bus_err = 1'b0;
      cu_state   = S_IF;
    end
  end

  assign cu_instret = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed scenarios plus randomized instruction stream.
// Latency: the reference model predicts every cycle of every instruction, stalls included.
// Backpressure: mem_rdy is driven low for randomized stall lengths, including timeouts.
module tb_mc_control_unit;
  localparam int TO = 4;
  localparam int IW = 8;

  // Phase and instruction-kind codes used only by the reference model
  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;
  localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_I = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    logic [3:0] aluc;
    bit         sext;
    bit         imm;
    bit         sh;
  } ins_t;

  typedef struct {
    int ph;
    bit rdy;
    bit to;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] ir_op, ir_func;
  logic alu_zero, mem_rdy;
  logic [3:0] cu_aluc;
  logic cu_pcwr, cu_irwr, cu_memrd, cu_memwr, cu_regwr, cu_m2reg;
  logic cu_aluimm, cu_shift, cu_sext, cu_jal, cu_illegal, cu_bus_err;
  logic [1:0] cu_pcsrc, cu_regdst;
  logic [2:0] cu_state;
  logic [IW-1:0] cu_instret;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_ret = '0;
  ins_t tbl[$];

  always #5 clk = ~clk;

  mc_control_unit #(.INSTRET_W(IW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .ir_func(ir_func),
    .alu_zero(alu_zero), .mem_rdy(mem_rdy), .cu_aluc(cu_aluc), .cu_pcwr(cu_pcwr),
    .cu_pcsrc(cu_pcsrc), .cu_irwr(cu_irwr), .cu_memrd(cu_memrd), .cu_memwr(cu_memwr),
    .cu_regwr(cu_regwr), .cu_regdst(cu_regdst), .cu_m2reg(cu_m2reg),
    .cu_aluimm(cu_aluimm), .cu_shift(cu_shift), .cu_sext(cu_sext), .cu_jal(cu_jal),
    .cu_illegal(cu_illegal), .cu_bus_err(cu_bus_err), .cu_state(cu_state),
    .cu_instret(cu_instret)
  );

  function automatic logic [19:0] obs_vec();
    return {cu_state, cu_pcwr, cu_pcsrc, cu_irwr, cu_memrd, cu_memwr, cu_regwr,
            cu_regdst, cu_m2reg, cu_jal, cu_illegal, cu_bus_err, cu_aluc};
  endfunction

  // Reference: what each phase of an instruction must drive
  function automatic logic [19:0] expect_out(int ph, ins_t i, bit rdy, bit zero, bit to);
    logic [2:0] st = 3'(ph);
    logic pcwr = 0, irwr = 0, memrd = 0, memwr = 0, regwr = 0, m2reg = 0;
    logic jal = 0, ill = 0, berr = 0;
    logic [1:0] pcsrc = 0, regdst = 0;
    logic [3:0] aluc = 0;
    case (ph)
      P_IF: begin
        memrd = 1;
        if (rdy) begin irwr = 1; pcwr = 1; end
        else if (to) berr = 1;
      end
      P_ID: begin
        if (i.k == K_J)   begin pcwr = 1; pcsrc = 2'b10; end
        if (i.k == K_JAL) begin pcwr = 1; pcsrc = 2'b10; regwr = 1; regdst = 2'b10; jal = 1; end
        if (i.k == K_JR)  begin pcwr = 1; pcsrc = 2'b11; end
        if (i.k == K_ILL) ill = 1;
      end
      P_EXE: begin
        aluc = i.aluc;
        if ((i.k == K_BEQ && zero) || (i.k == K_BNE && !zero)) begin pcwr = 1; pcsrc = 2'b01; end
      end
      P_MEM: begin
        if (i.k == K_LW) memrd = 1;
        if (i.k == K_SW) memwr = rdy || !to;
        berr = !rdy && to;
      end
      P_WB: begin
        regwr = 1;
        regdst = (i.k == K_R) ? 2'b01 : 2'b00;
        m2reg = (i.k == K_LW);
      end
      default: ;
    endcase
    return {st, pcwr, pcsrc, irwr, memrd, memwr, regwr, regdst, m2reg, jal, ill, berr, aluc};
  endfunction

  task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input int k,
                         input logic [3:0] aluc, input bit sext, input bit imm, input bit sh);
    ins_t t;
    t.op = op; t.fn = fn; t.k = k; t.aluc = aluc; t.sext = sext; t.imm = imm; t.sh = sh;
    tbl.push_back(t);
  endtask

  task automatic build_table();
    add_ins(6'h00, 6'h20, K_R, 4'b0000, 0, 0, 0);   // add
    add_ins(6'h00, 6'h22, K_R, 4'b0100, 0, 0, 0);   // sub
    add_ins(6'h00, 6'h24, K_R, 4'b0001, 0, 0, 0);   // and
    add_ins(6'h00, 6'h25, K_R, 4'b0101, 0, 0, 0);   // or
    add_ins(6'h00, 6'h26, K_R, 4'b0010, 0, 0, 0);   // xor
    add_ins(6'h00, 6'h00, K_R, 4'b0011, 0, 0, 1);   // sll
    add_ins(6'h00, 6'h02, K_R, 4'b0111, 0, 0, 1);   // srl
    add_ins(6'h00, 6'h03, K_R, 4'b1111, 0, 0, 1);   // sra
    add_ins(6'h00, 6'h08, K_JR, 4'b0000, 0, 0, 0);  // jr
    add_ins(6'h08, 6'h00, K_I, 4'b0000, 1, 1, 0);   // addi
    add_ins(6'h0C, 6'h00, K_I, 4'b0001, 0, 1, 0);   // andi
    add_ins(6'h0D, 6'h00, K_I, 4'b0101, 0, 1, 0);   // ori
    add_ins(6'h0E, 6'h00, K_I, 4'b0010, 0, 1, 0);   // xori
    add_ins(6'h0F, 6'h00, K_I, 4'b0110, 0, 1, 0);   // lui
    add_ins(6'h23, 6'h00, K_LW, 4'b0000, 1, 1, 0);  // lw
    add_ins(6'h2B, 6'h00, K_SW, 4'b0000, 1, 1, 0);  // sw
    add_ins(6'h04, 6'h00, K_BEQ, 4'b0100, 1, 0, 0); // beq
    add_ins(6'h05, 6'h00, K_BNE, 4'b0100, 1, 0, 0); // bne
    add_ins(6'h02, 6'h00, K_J, 4'b0000, 0, 0, 0);   // j
    add_ins(6'h03, 6'h00, K_JAL, 4'b0000, 0, 0, 0); // jal
    add_ins(6'h3F, 6'h00, K_ILL, 4'b0000, 0, 0, 0); // undefined opcode
    add_ins(6'h00, 6'h3F, K_ILL, 4'b0000, 0, 0, 0); // undefined funct
  endtask

  // One cycle: drive at the falling edge, leave outputs to settle before the rising edge
  task automatic tick(input bit rdy, input bit zero);
    @(negedge clk);
    mem_rdy = rdy;
    alu_zero = zero;
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ir_op = 6'h00; ir_func = 6'h20;
    tick(1, 0);
    checks++; if (obs_vec() !== 20'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs_vec()); end
    checks++; if (cu_instret !== '0) begin errors++; $display("FAIL reset_instret got %0d want 0", cu_instret); end
    mem_rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (cu_memrd !== 1'b1 || cu_irwr !== 1'b0 || cu_state !== 3'd0) begin
      errors++; $display("FAIL reset_release memrd=%b irwr=%b state=%0d want 1 0 0", cu_memrd, cu_irwr, cu_state); end
  endtask

  task automatic test_add();
    ir_op = 6'h00; ir_func = 6'h20;
    tick(1, 0);
    checks++; if (cu_state !== 3'd0 || cu_irwr !== 1'b1 || cu_pcwr !== 1'b1 || cu_pcsrc !== 2'b00) begin
      errors++; $display("FAIL add_if state=%0d irwr=%b pcwr=%b pcsrc=%b want 0 1 1 00", cu_state, cu_irwr, cu_pcwr, cu_pcsrc); end
    tick(1, 0);
    checks++; if (cu_state !== 3'd1 || cu_pcwr !== 1'b0 || cu_regwr !== 1'b0) begin
      errors++; $display("FAIL add_id state=%0d pcwr=%b regwr=%b want 1 0 0", cu_state, cu_pcwr, cu_regwr); end
    tick(1, 0);
    checks++; if (cu_state !== 3'd2 || cu_aluc !== 4'b0000 || cu_aluimm !== 1'b0) begin
      errors++; $display("FAIL add_exe state=%0d aluc=%b aluimm=%b want 2 0000 0", cu_state, cu_aluc, cu_aluimm); end
    tick(1, 0);
    checks++; if (cu_state !== 3'd4 || cu_regwr !== 1'b1 || cu_regdst !== 2'b01 || cu_m2reg !== 1'b0) begin
      errors++; $display("FAIL add_wb state=%0d regwr=%b regdst=%b m2reg=%b want 4 1 01 0", cu_state, cu_regwr, cu_regdst, cu_m2reg); end
    exp_ret++;
    tick(0, 0);
    checks++; if (cu_state !== 3'd0 || cu_instret !== exp_ret) begin
      errors++; $display("FAIL add_retire state=%0d instret=%0d want 0 %0d", cu_state, cu_instret, exp_ret); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'h04, 6'h04, 6'h05};
    bit zs [3] = '{1'b1, 1'b0, 1'b0};
    bit tk [3] = '{1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 3; n++) begin
      ir_op = ops[n]; ir_func = 6'h00;
      tick(1, 0);
      tick(1, 0);
      tick(1, zs[n]);
      checks++; if (cu_state !== 3'd2 || cu_aluc !== 4'b0100 || cu_pcwr !== tk[n] || cu_pcsrc !== (tk[n] ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL branch%0d_exe state=%0d aluc=%b pcwr=%b pcsrc=%b want 2 0100 %b", n, cu_state, cu_aluc, cu_pcwr, cu_pcsrc, tk[n]); end
      exp_ret++;
      tick(0, 0);
      checks++; if (cu_state !== 3'd0 || cu_instret !== exp_ret) begin
        errors++; $display("FAIL branch%0d_done state=%0d instret=%0d want 0 %0d", n, cu_state, cu_instret, exp_ret); end
    end
  endtask

  task automatic test_lw_stall();
    ir_op = 6'h23; ir_func = 6'h00;
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    checks++; if (cu_aluimm !== 1'b1 || cu_sext !== 1'b1 || cu_aluc !== 4'b0000) begin
      errors++; $display("FAIL lw_exe aluimm=%b sext=%b aluc=%b want 1 1 0000", cu_aluimm, cu_sext, cu_aluc); end
    for (int s = 0; s < 4; s++) begin
      tick(s == 3, 0);
      checks++; if (cu_state !== 3'd3 || cu_memrd !== 1'b1 || cu_bus_err !== 1'b0) begin
        errors++; $display("FAIL lw_mem%0d state=%0d memrd=%b bus_err=%b want 3 1 0", s, cu_state, cu_memrd, cu_bus_err); end
    end
    tick(1, 0);
    checks++; if (cu_state !== 3'd4 || cu_m2reg !== 1'b1 || cu_regwr !== 1'b1 || cu_regdst !== 2'b00) begin
      errors++; $display("FAIL lw_wb state=%0d m2reg=%b regwr=%b regdst=%b want 4 1 1 00", cu_state, cu_m2reg, cu_regwr, cu_regdst); end
    exp_ret++;
    tick(0, 0);
    checks++; if (cu_state !== 3'd0 || cu_instret !== exp_ret) begin
      errors++; $display("FAIL lw_done state=%0d instret=%0d want 0 %0d", cu_state, cu_instret, exp_ret); end
  endtask

  task automatic test_timeout();
    ir_op = 6'h2B; ir_func = 6'h00;
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    for (int s = 0; s < 3; s++) begin
      tick(0, 0);
      checks++; if (cu_memwr !== 1'b1 || cu_bus_err !== 1'b0) begin
        errors++; $display("FAIL sw_wait%0d memwr=%b bus_err=%b want 1 0", s, cu_memwr, cu_bus_err); end
    end
    tick(0, 0);
    checks++; if (cu_bus_err !== 1'b1 || cu_memwr !== 1'b0 || cu_pcwr !== 1'b0 || cu_regwr !== 1'b0) begin
      errors++; $display("FAIL sw_timeout bus_err=%b memwr=%b pcwr=%b regwr=%b want 1 0 0 0", cu_bus_err, cu_memwr, cu_pcwr, cu_regwr); end
    tick(0, 0);
    checks++; if (cu_state !== 3'd0 || cu_bus_err !== 1'b0 || cu_instret !== exp_ret) begin
      errors++; $display("FAIL sw_after state=%0d bus_err=%b instret=%0d want 0 0 %0d", cu_state, cu_bus_err, cu_instret, exp_ret); end
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    checks++; if (cu_bus_err !== 1'b1 || cu_irwr !== 1'b0 || cu_state !== 3'd0) begin
      errors++; $display("FAIL if_timeout bus_err=%b irwr=%b state=%0d want 1 0 0", cu_bus_err, cu_irwr, cu_state); end
    tick(0, 0);
    checks++; if (cu_bus_err !== 1'b0) begin
      errors++; $display("FAIL if_timeout_clear bus_err=%b want 0", cu_bus_err); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'h3F, 6'h00};
    for (int n = 0; n < 2; n++) begin
      ir_op = ops[n]; ir_func = 6'h3F;
      tick(1, 0);
      tick(1, 0);
      checks++; if (cu_state !== 3'd1 || cu_illegal !== 1'b1 || cu_pcwr !== 1'b0 || cu_regwr !== 1'b0) begin
        errors++; $display("FAIL illegal%0d_id state=%0d illegal=%b pcwr=%b regwr=%b want 1 1 0 0", n, cu_state, cu_illegal, cu_pcwr, cu_regwr); end
      tick(0, 0);
      checks++; if (cu_state !== 3'd0 || cu_illegal !== 1'b0 || cu_instret !== exp_ret) begin
        errors++; $display("FAIL illegal%0d_after state=%0d illegal=%b instret=%0d want 0 0 %0d", n, cu_state, cu_illegal, cu_instret, exp_ret); end
    end
  endtask

  task automatic test_reset_mid();
    ir_op = 6'h2B; ir_func = 6'h00;
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    checks++; if (cu_memwr !== 1'b1) begin errors++; $display("FAIL rstmid_pre memwr=%b want 1", cu_memwr); end
    rst_n = 1'b0;
    #1;
    exp_ret = '0;
    checks++; if (cu_memwr !== 1'b0 || cu_state !== 3'd0 || cu_instret !== exp_ret) begin
      errors++; $display("FAIL rstmid memwr=%b state=%0d instret=%0d want 0 0 0", cu_memwr, cu_state, cu_instret); end
    mem_rdy = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ins_t ins;
      cyc_t cq[$];
      int if_st, mem_st;
      bit aborted;
      logic [5:0] op_v, fn_v;
      logic [19:0] exp_v;
      ins = tbl[$urandom_range(tbl.size() - 1)];
      op_v = ins.op;
      fn_v = (ins.op == 6'h00) ? ins.fn : 6'($urandom);
      if_st = $urandom_range(TO - 1);
      mem_st = ($urandom_range(7) == 0) ? TO : $urandom_range(TO - 1);
      aborted = 0;
      for (int s = 0; s < if_st; s++) cq.push_back('{P_IF, 1'b0, 1'b0});
      cq.push_back('{P_IF, 1'b1, 1'b0});
      cq.push_back('{P_ID, 1'($urandom), 1'b0});
      if (ins.k inside {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE}) cq.push_back('{P_EXE, 1'($urandom), 1'b0});
      if (ins.k == K_LW || ins.k == K_SW) begin
        for (int s = 0; s < mem_st; s++) cq.push_back('{P_MEM, 1'b0, (s == TO - 1)});
        if (mem_st < TO) cq.push_back('{P_MEM, 1'b1, 1'b0});
        else aborted = 1;
      end
      if ((ins.k == K_R || ins.k == K_I || ins.k == K_LW) && !aborted) cq.push_back('{P_WB, 1'($urandom), 1'b0});
      foreach (cq[c]) begin
        @(negedge clk);
        if (c == 0) begin ir_op = op_v; ir_func = fn_v; end
        mem_rdy = cq[c].rdy;
        alu_zero = 1'($urandom);
        #2;
        exp_v = expect_out(cq[c].ph, ins, cq[c].rdy, alu_zero, cq[c].to);
        checks++;
        if ({obs_vec(), cu_instret} !== {exp_v, exp_ret}) begin
          errors++;
          $display("FAIL random n=%0d cyc=%0d ph=%0d op=%b fn=%b got %h/%0d want %h/%0d",
                   n, c, cq[c].ph, op_v, fn_v, obs_vec(), cu_instret, exp_v, exp_ret);
        end
        if (cq[c].ph == P_EXE) begin
          checks++;
          if ({cu_sext, cu_aluimm, cu_shift} !== {ins.sext, ins.imm, ins.sh}) begin
            errors++;
            $display("FAIL random_opsel n=%0d op=%b fn=%b got %b want %b", n, op_v, fn_v,
                     {cu_sext, cu_aluimm, cu_shift}, {ins.sext, ins.imm, ins.sh});
          end
        end
      end
      if (ins.k != K_ILL && !aborted) exp_ret++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_rdy = 1'b1;
    alu_zero = 1'b0;
    ir_op = 6'h00;
    ir_func = 6'h00;
    build_table();
    test_reset();
    test_add();
    test_branch();
    test_lw_stall();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
